// File: rtl/ram_1p_arb_pkg.sv
// Shared definitions for the single-port RAM arbiter: RAM pin polarities,
// default geometry of the shared buffer and the command type.
package ram_1p_arb_pkg;

  localparam logic CEN_ON  = 1'b0;
  localparam logic CEN_OFF = 1'b1;
  localparam logic WEN_WR  = 1'b0;
  localparam logic WEN_RD  = 1'b1;
  localparam logic OEN_ON  = 1'b0;
  localparam logic OEN_OFF = 1'b1;

  localparam int DEF_REQ_NUM    = 2;
  localparam int DEF_WORD_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 8;
  localparam int DEF_MAX_BURST  = 4;

  typedef enum logic {
    CMD_RD = 1'b0,
    CMD_WR = 1'b1
  } cmd_e;

  // Index width that stays legal for a single-entry vector.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/ram_1p_arb_if.sv
// Requester-side command/return bus of the shared RAM arbiter.
interface ram_1p_arb_if import ram_1p_arb_pkg::*; #(
  parameter int REQ_NUM    = DEF_REQ_NUM,
  parameter int Word_Width = DEF_WORD_WIDTH,
  parameter int Addr_Width = DEF_ADDR_WIDTH
) ();

  logic [REQ_NUM-1:0]            req_i;
  logic [REQ_NUM-1:0]            lock_i;
  logic [REQ_NUM-1:0]            we_i;
  logic [REQ_NUM*Addr_Width-1:0] addr_i;
  logic [REQ_NUM*Word_Width-1:0] data_i;
  logic [REQ_NUM-1:0]            gnt_o;
  logic [REQ_NUM-1:0]            rd_vld_o;
  logic [Word_Width-1:0]         rd_data_o;

  modport master (
    output req_i, lock_i, we_i, addr_i, data_i,
    input  gnt_o, rd_vld_o, rd_data_o
  );

  modport slave (
    input  req_i, lock_i, we_i, addr_i, data_i,
    output gnt_o, rd_vld_o, rd_data_o
  );

endinterface

// File: rtl/ram_1p_arb_rr_arb_core.sv
// Combinational round-robin picker: first set request searching upward from
// ptr with wrap-around, returned both one-hot and as an index.
module rr_arb_core import ram_1p_arb_pkg::*; #(
  parameter int N  = DEF_REQ_NUM,
  parameter int PW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] idx
);

  logic found;

  // Outer loop walks priority order; inner loop keeps every bit select constant.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && req[j] && (j == (32'(ptr) + i) % N)) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          idx    = PW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/ram_1p_arb.sv
// Round-robin arbiter with burst lock sharing one single-port RAM; registers the
// winning command onto the RAM pins and returns read data tagged to its requester.
module ram_1p_arb import ram_1p_arb_pkg::*; #(
  parameter int REQ_NUM    = DEF_REQ_NUM,
  parameter int Word_Width = DEF_WORD_WIDTH,
  parameter int Addr_Width = DEF_ADDR_WIDTH,
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_1p_arb_if.slave           bus,
  output logic                  ram_cen_o,
  output logic                  ram_wen_o,
  output logic                  ram_oen_o,
  output logic [Addr_Width-1:0] ram_addr_o,
  output logic [Word_Width-1:0] ram_data_o,
  input  logic [Word_Width-1:0] ram_data_i
);

  localparam int PW = clog2_min1(REQ_NUM);
  localparam int CW = $clog2(MAX_BURST + 1);

  logic [PW-1:0]         ptr;
  logic [PW-1:0]         owner;
  logic                  owner_vld;
  logic [CW-1:0]         burst_cnt;
  logic [REQ_NUM-1:0]    rr_gnt;
  logic [PW-1:0]         rr_idx;
  logic [REQ_NUM-1:0]    win_gnt;
  logic [PW-1:0]         win_idx;
  logic                  any_gnt;
  logic                  lock_hit;
  logic                  owner_locked;
  cmd_e                  win_cmd;
  logic [Addr_Width-1:0] win_addr;
  logic [Word_Width-1:0] win_data;
  logic [REQ_NUM-1:0]    tag;
  logic [REQ_NUM-1:0]    rd_vld;

  rr_arb_core #(
    .N  (REQ_NUM),
    .PW (PW)
  ) u_core (
    .req (bus.req_i),
    .ptr (ptr),
    .gnt (rr_gnt),
    .idx (rr_idx)
  );

  always_comb begin
    owner_locked = 1'b0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      if (owner == PW'(k)) owner_locked = bus.req_i[k] && bus.lock_i[k];
    end
    lock_hit = owner_vld && owner_locked && (burst_cnt < CW'(MAX_BURST));

    win_gnt = rr_gnt;
    win_idx = rr_idx;
    if (lock_hit) begin
      win_gnt = '0;
      win_idx = owner;
      for (int unsigned k = 0; k < REQ_NUM; k++) begin
        if (owner == PW'(k)) win_gnt[k] = 1'b1;
      end
    end
    any_gnt = |win_gnt;

    win_cmd  = CMD_RD;
    win_addr = '0;
    win_data = '0;
    for (int unsigned k = 0; k < REQ_NUM; k++) begin
      if (win_idx == PW'(k)) begin
        win_cmd  = cmd_e'(bus.we_i[k]);
        win_addr = bus.addr_i[k*Addr_Width +: Addr_Width];
        win_data = bus.data_i[k*Word_Width +: Word_Width];
      end
    end
  end

  assign bus.gnt_o = win_gnt;

  // Pointer always advances past the winner, so an expired burst resumes rr from w+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      owner     <= '0;
      owner_vld <= 1'b0;
      burst_cnt <= '0;
    end else if (any_gnt) begin
      ptr       <= (win_idx == PW'(REQ_NUM - 1)) ? '0 : win_idx + PW'(1);
      owner     <= win_idx;
      owner_vld <= 1'b1;
      burst_cnt <= (owner_vld && owner == win_idx && burst_cnt < CW'(MAX_BURST))
                   ? burst_cnt + CW'(1) : CW'(1);
    end else begin
      owner_vld <= 1'b0;
      burst_cnt <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_cen_o  <= CEN_OFF;
      ram_wen_o  <= WEN_RD;
      ram_oen_o  <= OEN_OFF;
      ram_addr_o <= '0;
      ram_data_o <= '0;
      tag        <= '0;
      rd_vld     <= '0;
    end else begin
      if (any_gnt) begin
        ram_cen_o  <= CEN_ON;
        ram_wen_o  <= (win_cmd == CMD_WR) ? WEN_WR : WEN_RD;
        ram_addr_o <= win_addr;
        ram_data_o <= win_data;
      end else begin
        ram_cen_o <= CEN_OFF;
        ram_wen_o <= WEN_RD;
      end
      tag       <= (any_gnt && win_cmd == CMD_RD) ? win_gnt : '0;
      rd_vld    <= tag;
      ram_oen_o <= (|tag) ? OEN_ON : OEN_OFF;
    end
  end

  assign bus.rd_vld_o  = rd_vld;
  assign bus.rd_data_o = (|rd_vld) ? ram_data_i : '0;

  for (genvar k = 0; k < REQ_NUM; k++) begin : g_hold
    a_cmd_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (bus.req_i[k] && !win_gnt[k]) |=> (!bus.req_i[k] ||
        ($stable(bus.we_i[k]) &&
         $stable(bus.addr_i[k*Addr_Width +: Addr_Width]) &&
         $stable(bus.data_i[k*Word_Width +: Word_Width]))));
  end

endmodule
